// File: rtl/mdio_scheduler_pkg.sv
// Shared types and frame layout for the two-requester MDIO scheduler.
// Frame builder keeps the bit packing in one place.
package mdio_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_XFER,
    S_RESP
  } state_t;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] ST_CODE  = 2'b01;
  localparam logic [1:0] TA_WR    = 2'b10;

  localparam int F_ST_LSB   = 30;
  localparam int F_OP_LSB   = 28;
  localparam int F_PHY_LSB  = 23;
  localparam int F_REG_LSB  = 18;
  localparam int F_TA_LSB   = 16;
  localparam int F_DATA_LSB = 0;

  function automatic logic [31:0] mk_frame(
    input logic        rd,
    input logic [4:0]  phy,
    input logic [4:0]  rg,
    input logic [15:0] wd
  );
    logic [31:0] f;
    f = '0;
    f[F_ST_LSB +: 2]    = ST_CODE;
    f[F_OP_LSB +: 2]    = rd ? OP_READ : OP_WRITE;
    f[F_PHY_LSB +: 5]   = phy;
    f[F_REG_LSB +: 5]   = rg;
    f[F_TA_LSB +: 2]    = rd ? 2'b00 : TA_WR;
    f[F_DATA_LSB +: 16] = rd ? 16'h0000 : wd;
    return f;
  endfunction

endpackage

// File: rtl/mdio_scheduler_if.sv
// Host-side request/response bundle plus the generator link.
// slave is the scheduler's view, master is the surrounding logic.
interface mdio_scheduler_if;

  logic [1:0]  REQ;
  logic [1:0]  OP;
  logic [9:0]  PHY_ADDR;
  logic [9:0]  REG_ADDR;
  logic [31:0] WR_DATA_IN;
  logic [1:0]  GNT;
  logic [1:0]  DONE;
  logic        ERR;
  logic [15:0] RD_DATA_OUT;
  logic        BUSY;
  logic        MDIO_START;
  logic [31:0] T_DATA;
  logic        MDIO_DONE;
  logic [15:0] RD_DATA;

  modport slave (
    input  REQ, OP, PHY_ADDR, REG_ADDR, WR_DATA_IN,
    input  MDIO_DONE, RD_DATA,
    output GNT, DONE, ERR, RD_DATA_OUT, BUSY,
    output MDIO_START, T_DATA
  );

  modport master (
    output REQ, OP, PHY_ADDR, REG_ADDR, WR_DATA_IN,
    output MDIO_DONE, RD_DATA,
    input  GNT, DONE, ERR, RD_DATA_OUT, BUSY,
    input  MDIO_START, T_DATA
  );

endinterface

// File: rtl/mdio_scheduler_arb.sv
// Two-way round-robin pick: pointer requester first, else the other.
// Purely combinational; the pointer lives in the scheduler.
module mdio_rr_arb (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] win,
  output logic       any_req
);

  always_comb begin
    win = 2'b00;
    if (req[ptr]) begin
      win[ptr] = 1'b1;
    end else if (req[~ptr]) begin
      win[~ptr] = 1'b1;
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/mdio_scheduler.sv
// MDIO management scheduler: arbitrate, frame, launch, time out.
// All outputs are registered; DONE lands one cycle after RESP.
module mdio_scheduler
  import mdio_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst,
  mdio_scheduler_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [1:0]       win_q, win_d;
  logic             rd_op_q, rd_op_d;
  logic [4:0]       phy_q, phy_d;
  logic [4:0]       reg_q, reg_d;
  logic [15:0]      wd_q, wd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic             err_q, err_d;
  logic [15:0]      rd_q, rd_d;
  logic             busy_q, busy_d;
  logic             start_q, start_d;
  logic [31:0]      tdata_q, tdata_d;
  logic [1:0]       win;
  logic             any_req;
  logic             sel;

  mdio_rr_arb u_arb (
    .req     (bus.REQ),
    .ptr     (ptr_q),
    .win     (win),
    .any_req (any_req)
  );

  assign sel = win[1];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    rd_op_d = rd_op_q;
    phy_d   = phy_q;
    reg_d   = reg_q;
    wd_d    = wd_q;
    cnt_d   = cnt_q;
    gnt_d   = 2'b00;
    done_d  = 2'b00;
    err_d   = err_q;
    rd_d    = rd_q;
    start_d = start_q;
    tdata_d = tdata_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          win_d   = win;
          rd_op_d = sel ? bus.OP[1] : bus.OP[0];
          phy_d   = sel ? bus.PHY_ADDR[9:5] : bus.PHY_ADDR[4:0];
          reg_d   = sel ? bus.REG_ADDR[9:5] : bus.REG_ADDR[4:0];
          wd_d    = sel ? bus.WR_DATA_IN[31:16] : bus.WR_DATA_IN[15:0];
          gnt_d   = win;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        tdata_d = mk_frame(rd_op_q, phy_q, reg_q, wd_q);
        start_d = 1'b1;
        cnt_d   = '0;
        state_d = S_XFER;
      end
      S_XFER: begin
        // a done on the limit cycle still counts as success
        if (bus.MDIO_DONE) begin
          rd_d    = rd_op_q ? bus.RD_DATA : 16'h0000;
          err_d   = 1'b0;
          start_d = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LIM) begin
          rd_d    = 16'h0000;
          err_d   = 1'b1;
          start_d = 1'b0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        done_d  = win_q;
        ptr_d   = win_q[0];
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      win_q   <= 2'b00;
      rd_op_q <= 1'b0;
      phy_q   <= '0;
      reg_q   <= '0;
      wd_q    <= '0;
      cnt_q   <= '0;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      err_q   <= 1'b0;
      rd_q    <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      tdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      rd_op_q <= rd_op_d;
      phy_q   <= phy_d;
      reg_q   <= reg_d;
      wd_q    <= wd_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      tdata_q <= tdata_d;
    end
  end

  assign bus.GNT         = gnt_q;
  assign bus.DONE        = done_q;
  assign bus.ERR         = err_q;
  assign bus.RD_DATA_OUT = rd_q;
  assign bus.BUSY        = busy_q;
  assign bus.MDIO_START  = start_q;
  assign bus.T_DATA      = tdata_q;

endmodule
